// File: rtl/time_view_pkg.sv
// Shared field layout, limits and binary-to-BCD helper for the time_view clock core.
// Pure declarations; no logic or state.
package time_view_pkg;

    localparam int BCD_W  = 20;
    localparam int HT_LSB = 18;
    localparam int HT_W   = 2;
    localparam int HU_LSB = 14;
    localparam int MT_LSB = 11;
    localparam int MU_LSB = 7;
    localparam int ST_LSB = 4;
    localparam int SU_LSB = 0;
    localparam int TEN_W  = 3;
    localparam int UNIT_W = 4;

    localparam logic [4:0] MAX_HOUR    = 5'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // Returns {tens[2:0], units[3:0]} for a value in 0..59.
    function automatic logic [6:0] bin2bcd60(input logic [5:0] v);
        logic [2:0] tens;
        logic [3:0] units;
        if (v >= 6'd50) begin
            tens  = 3'd5;
            units = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            tens  = 3'd4;
            units = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            tens  = 3'd3;
            units = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            tens  = 3'd2;
            units = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            tens  = 3'd1;
            units = 4'(v - 6'd10);
        end else begin
            tens  = 3'd0;
            units = 4'(v);
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/time_view_if.sv
// Control/display bundle between the input layer and the clock core.
// master drives buttons/switches and reads the display word; slave is the core.
interface time_view_if;
    logic        mode12h;
    logic        set_time;
    logic        set_alarm;
    logic        button1;
    logic        button2;
    logic [19:0] stime_alarm;
    logic        sam_pm;
    logic [19:0] hh_mm_ss;
    logic        am_pm;
    logic        alarm_hit;

    modport master (
        output mode12h, set_time, set_alarm, button1, button2, stime_alarm, sam_pm,
        input  hh_mm_ss, am_pm, alarm_hit
    );

    modport slave (
        input  mode12h, set_time, set_alarm, button1, button2, stime_alarm, sam_pm,
        output hh_mm_ss, am_pm, alarm_hit
    );
endinterface

// File: rtl/time_bcd_fmt.sv
// Combinational binary time to packed BCD display word, 12h or 24h hour form.
// Zero latency; no flow control.
module time_bcd_fmt
    import time_view_pkg::*;
(
    input  logic [4:0]       hour,
    input  logic [5:0]       minute,
    input  logic [5:0]       second,
    input  logic             mode12h,
    output logic [BCD_W-1:0] bcd
);

    logic [4:0] disp_hour;
    logic [1:0] h_tens;
    logic [3:0] h_units;

    always_comb begin
        disp_hour = hour;
        if (mode12h) begin
            if (hour == 5'd0 || hour == 5'd12) begin
                disp_hour = 5'd12;
            end else if (hour > 5'd12) begin
                disp_hour = hour - 5'd12;
            end
        end

        h_tens  = 2'd0;
        h_units = 4'(disp_hour);
        if (disp_hour >= 5'd20) begin
            h_tens  = 2'd2;
            h_units = 4'(disp_hour - 5'd20);
        end else if (disp_hour >= 5'd10) begin
            h_tens  = 2'd1;
            h_units = 4'(disp_hour - 5'd10);
        end
    end

    assign bcd = {h_tens, h_units, bin2bcd60(minute), bin2bcd60(second)};

endmodule

// File: rtl/time_view.sv
// Real-time clock core: 24h binary time, button time-set, one alarm, registered BCD display.
// Display/am_pm/alarm_hit lag internal state by one cycle; inputs are never back-pressured.
module time_view
    import time_view_pkg::*;
#(
    parameter int CLK_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    time_view_if.slave tv
);

    localparam int            PW       = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0]    presc;
    logic [4:0]       hour;
    logic [5:0]       minute;
    logic [5:0]       second;
    logic             b1_q;
    logic             b2_q;
    logic             sa_q;
    logic             armed;
    logic [4:0]       al_hour;
    logic [5:0]       al_min;
    logic [5:0]       al_sec;
    logic [BCD_W-1:0] disp_q;
    logic             am_pm_q;
    logic             hit_q;

    logic b1_rise, b2_rise, sa_rise, tick;

    assign b1_rise = tv.button1 & ~b1_q;
    assign b2_rise = tv.button2 & ~b2_q;
    assign sa_rise = tv.set_alarm & ~sa_q;
    assign tick    = (presc == PRE_LAST);

    // Set mode keeps the hour in the half chosen by sam_pm; button1 steps within that half.
    logic [4:0] hour_mod, hour_inc, hour_set;

    assign hour_mod = (hour >= 5'd12) ? hour - 5'd12 : hour;
    assign hour_inc = !b1_rise ? hour_mod : ((hour_mod == 5'd11) ? 5'd0 : hour_mod + 5'd1);
    assign hour_set = hour_inc + (tv.sam_pm ? 5'd12 : 5'd0);

    logic [1:0] a_ht;
    logic [3:0] a_hu, a_mu, a_su;
    logic [2:0] a_mt, a_st;
    logic [5:0] a_hval, a_min, a_sec;
    logic [4:0] a_h12, a_h24;
    logic       digits_ok, hour_ok;

    assign a_ht = tv.stime_alarm[HT_LSB +: HT_W];
    assign a_hu = tv.stime_alarm[HU_LSB +: UNIT_W];
    assign a_mt = tv.stime_alarm[MT_LSB +: TEN_W];
    assign a_mu = tv.stime_alarm[MU_LSB +: UNIT_W];
    assign a_st = tv.stime_alarm[ST_LSB +: TEN_W];
    assign a_su = tv.stime_alarm[SU_LSB +: UNIT_W];

    assign a_hval = 6'(a_ht) * 6'd10 + 6'(a_hu);
    assign a_min  = 6'(a_mt) * 6'd10 + 6'(a_mu);
    assign a_sec  = 6'(a_st) * 6'd10 + 6'(a_su);

    assign digits_ok = (a_hu <= 4'd9) && (a_mu <= 4'd9) && (a_su <= 4'd9) &&
                       (a_mt <= 3'd5) && (a_st <= 3'd5);
    assign hour_ok   = tv.mode12h ? (a_hval >= 6'd1 && a_hval <= 6'd12)
                                  : (a_hval <= 6'(MAX_HOUR));

    // 12 AM is hour 0, 12 PM is hour 12.
    assign a_h12 = (a_hval == 6'd12) ? 5'd0 : a_hval[4:0];
    assign a_h24 = tv.mode12h ? (a_h12 + (tv.sam_pm ? 5'd12 : 5'd0)) : a_hval[4:0];

    logic [BCD_W-1:0] fmt_word;

    time_bcd_fmt u_fmt (
        .hour    (hour),
        .minute  (minute),
        .second  (second),
        .mode12h (tv.mode12h),
        .bcd     (fmt_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            hour    <= '0;
            minute  <= '0;
            second  <= '0;
            b1_q    <= 1'b0;
            b2_q    <= 1'b0;
            sa_q    <= 1'b0;
            armed   <= 1'b0;
            al_hour <= '0;
            al_min  <= '0;
            al_sec  <= '0;
            disp_q  <= '0;
            am_pm_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            b1_q <= tv.button1;
            b2_q <= tv.button2;
            sa_q <= tv.set_alarm;

            if (tv.set_time) begin
                presc  <= '0;
                second <= '0;
                hour   <= hour_set;
                if (b2_rise) begin
                    minute <= (minute == MAX_MIN_SEC) ? 6'd0 : minute + 6'd1;
                end
            end else if (tick) begin
                presc <= '0;
                if (second == MAX_MIN_SEC) begin
                    second <= 6'd0;
                    if (minute == MAX_MIN_SEC) begin
                        minute <= 6'd0;
                        hour   <= (hour == MAX_HOUR) ? 5'd0 : hour + 5'd1;
                    end else begin
                        minute <= minute + 6'd1;
                    end
                end else begin
                    second <= second + 6'd1;
                end
            end else begin
                presc <= presc + PW'(1);
            end

            if (sa_rise && digits_ok && hour_ok) begin
                armed   <= 1'b1;
                al_hour <= a_h24;
                al_min  <= a_min;
                al_sec  <= a_sec;
            end

            disp_q  <= fmt_word;
            am_pm_q <= (hour >= 5'd12);
            hit_q   <= ~tv.set_time & armed & (hour == al_hour) &
                       (minute == al_min) & (second == al_sec);
        end
    end

    assign tv.hh_mm_ss  = disp_q;
    assign tv.am_pm     = am_pm_q;
    assign tv.alarm_hit = hit_q;

endmodule

// File: tb/tb_time_view.sv
// Bench for time_view: seconds-of-day reference model checked every cycle, plus directed sequences.
module tb_time_view;

    localparam int P = 1;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    time_view_if tv();

    time_view #(.CLK_PER_SEC(P)) dut (
        .clk (clk),
        .rst (rst),
        .tv  (tv)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state: time as seconds of day, alarm as seconds of day.
    int m_t, m_pre, m_alarm;
    bit m_armed, p_b1, p_b2, p_sa;

    typedef struct {
        int h;
        int m;
        bit m12;
        int eh;
        int em;
        bit eap;
    } fmt_vec_t;

    fmt_vec_t vecs[9];

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [19:0] bcd_word(input int h, input int m, input int s);
        logic [19:0] w;
        w = '0;
        w[19:18] = 2'(h / 10);
        w[17:14] = 4'(h % 10);
        w[13:11] = 3'(m / 10);
        w[10:7]  = 4'(m % 10);
        w[6:4]   = 3'(s / 10);
        w[3:0]   = 4'(s % 10);
        return w;
    endfunction

    function automatic logic [19:0] enc_alarm(input int t, input bit m12);
        int h;
        h = t / 3600;
        if (m12) h = (h % 12 == 0) ? 12 : h % 12;
        return bcd_word(h, (t / 60) % 60, t % 60);
    endfunction

    task automatic step();
        int h, m, s, dh, hv, ht, hu, mt, mu, st, su;
        bit ok;
        logic [19:0] e_word;
        logic e_ap, e_hit;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        dh = h;
        if (tv.mode12h) dh = (h % 12 == 0) ? 12 : h % 12;
        e_word = bcd_word(dh, m, s);
        e_ap   = (h >= 12);
        e_hit  = !tv.set_time && m_armed && (m_t == m_alarm);

        if (tv.set_alarm && !p_sa) begin
            ht = int'(tv.stime_alarm[19:18]);
            hu = int'(tv.stime_alarm[17:14]);
            mt = int'(tv.stime_alarm[13:11]);
            mu = int'(tv.stime_alarm[10:7]);
            st = int'(tv.stime_alarm[6:4]);
            su = int'(tv.stime_alarm[3:0]);
            ok = (hu <= 9) && (mu <= 9) && (su <= 9) && (mt <= 5) && (st <= 5);
            hv = ht * 10 + hu;
            if (tv.mode12h) begin
                ok = ok && (hv >= 1) && (hv <= 12);
                hv = hv % 12 + (tv.sam_pm ? 12 : 0);
            end else begin
                ok = ok && (hv <= 23);
            end
            if (ok) begin
                m_armed = 1'b1;
                m_alarm = hv * 3600 + (mt * 10 + mu) * 60 + st * 10 + su;
            end
        end

        if (tv.set_time) begin
            h = h % 12;
            if (tv.button1 && !p_b1) h = (h + 1) % 12;
            if (tv.sam_pm) h += 12;
            if (tv.button2 && !p_b2) m = (m + 1) % 60;
            m_t   = h * 3600 + m * 60;
            m_pre = 0;
        end else if (m_pre == P - 1) begin
            m_pre = 0;
            m_t   = (m_t + 1) % 86400;
        end else begin
            m_pre++;
        end
        p_b1 = tv.button1;
        p_b2 = tv.button2;
        p_sa = tv.set_alarm;

        @(posedge clk);
        #1;
        cyc++;
        chk("word", tv.hh_mm_ss, e_word);
        chk("am_pm", 20'(tv.am_pm), 20'(e_ap));
        chk("alarm_hit", 20'(tv.alarm_hit), 20'(e_hit));
    endtask

    task automatic press(input bit b1, input bit b2);
        tv.button1 = b1;
        tv.button2 = b2;
        step();
        tv.button1 = 1'b0;
        tv.button2 = 1'b0;
        step();
    endtask

    task automatic do_reset();
        tv.set_time    = 1'b0;
        tv.set_alarm   = 1'b0;
        tv.button1     = 1'b0;
        tv.button2     = 1'b0;
        tv.sam_pm      = 1'b0;
        tv.mode12h     = 1'b0;
        tv.stime_alarm = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word", tv.hh_mm_ss, 20'h00000);
        chk("rst_am_pm", 20'(tv.am_pm), 20'd0);
        chk("rst_hit", 20'(tv.alarm_hit), 20'd0);
        rst = 1'b1;
        m_t = 0; m_pre = 0; m_alarm = 0; m_armed = 1'b0;
        p_b1 = 1'b0; p_b2 = 1'b0; p_sa = 1'b0;
    endtask

    task automatic goto_hm(input int h, input int m);
        tv.set_time = 1'b1;
        tv.sam_pm   = (h >= 12);
        step();
        for (int i = 0; i < 12; i++)
            if ((m_t / 3600) % 12 != h % 12) press(1'b1, 1'b0);
        for (int i = 0; i < 60; i++)
            if ((m_t / 60) % 60 != m) press(1'b0, 1'b1);
        step();
    endtask

    task automatic pulse_alarm(input logic [19:0] val);
        tv.stime_alarm = val;
        tv.set_alarm   = 1'b1;
        step();
        tv.set_alarm   = 1'b0;
        step();
    endtask

    initial begin
        bit seen;
        int t;
        rst = 1'b0;
        vecs[0] = '{0, 0, 1'b0, 0, 0, 1'b0};
        vecs[1] = '{0, 0, 1'b1, 12, 0, 1'b0};
        vecs[2] = '{11, 59, 1'b1, 11, 59, 1'b0};
        vecs[3] = '{12, 5, 1'b1, 12, 5, 1'b1};
        vecs[4] = '{12, 5, 1'b0, 12, 5, 1'b1};
        vecs[5] = '{13, 30, 1'b1, 1, 30, 1'b1};
        vecs[6] = '{23, 59, 1'b0, 23, 59, 1'b1};
        vecs[7] = '{23, 59, 1'b1, 11, 59, 1'b1};
        vecs[8] = '{9, 7, 1'b0, 9, 7, 1'b0};

        do_reset();
        step();

        // Set AM: 12 edges on each button wrap the hour back to 0.
        tv.set_time = 1'b1;
        tv.sam_pm   = 1'b0;
        repeat (12) press(1'b1, 1'b1);
        step(); step();
        chk("set_am_word", tv.hh_mm_ss, 20'h00900);
        chk("set_am_ampm", 20'(tv.am_pm), 20'd0);

        // Set PM.
        tv.sam_pm = 1'b1;
        repeat (12) press(1'b1, 1'b1);
        step(); step();
        chk("set_pm_word", tv.hh_mm_ss, 20'h49200);
        chk("set_pm_ampm", 20'(tv.am_pm), 20'd1);
        tv.mode12h = 1'b1;
        step(); step();
        chk("set_pm_12h_word", tv.hh_mm_ss, 20'h49200);
        chk("set_pm_12h_ampm", 20'(tv.am_pm), 20'd1);

        // Both buttons in one cycle.
        tv.mode12h = 1'b0;
        press(1'b1, 1'b1);
        step(); step();
        chk("simul_word", tv.hh_mm_ss, 20'h4D280);

        // Run through midnight.
        goto_hm(23, 59);
        tv.set_time = 1'b0;
        repeat (60) step();
        chk("wrap_pre_word", tv.hh_mm_ss, 20'h8ECD9);
        chk("wrap_pre_ampm", 20'(tv.am_pm), 20'd1);
        step();
        chk("wrap_word", tv.hh_mm_ss, 20'h00000);
        chk("wrap_ampm", 20'(tv.am_pm), 20'd0);
        tv.mode12h = 1'b1;
        step();
        chk("wrap_12h_word", tv.hh_mm_ss, 20'h48001);

        // Alarm 01:32:46, then an invalid one that must be ignored.
        tv.mode12h = 1'b0;
        pulse_alarm({2'd0, 4'd1, 3'd3, 4'd2, 3'd4, 4'd6});
        pulse_alarm({2'd0, 4'd1, 3'd7, 4'd2, 3'd4, 4'd6});
        goto_hm(1, 32);
        tv.set_time = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (tv.alarm_hit) begin
                seen = 1'b1;
                chk("alarm_rise_word", tv.hh_mm_ss, 20'h05946);
                step();
                chk("alarm_fall_hit", 20'(tv.alarm_hit), 20'd0);
                chk("alarm_fall_word", tv.hh_mm_ss, 20'h05947);
                break;
            end
        end
        chk("alarm_seen", 20'(seen), 20'd1);

        // Alarm matching the set time stays low until set mode is left.
        pulse_alarm({2'd0, 4'd1, 3'd3, 4'd3, 3'd0, 4'd0});
        goto_hm(1, 33);
        chk("hit_in_set", 20'(tv.alarm_hit), 20'd0);
        tv.set_time = 1'b0;
        step();
        chk("hit_after_set", 20'(tv.alarm_hit), 20'd1);

        // Display-format table.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            tv.mode12h = vecs[i].m12;
            goto_hm(vecs[i].h, vecs[i].m);
            step(); step();
            chk("fmt_word", tv.hh_mm_ss, bcd_word(vecs[i].eh, vecs[i].em, 0));
            chk("fmt_ampm", 20'(tv.am_pm), 20'(vecs[i].eap));
        end

        // Randomised traffic against the model.
        tv.set_time = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) tv.set_time = ~tv.set_time;
            if ($urandom_range(0, 29) == 0) tv.mode12h = ~tv.mode12h;
            if ($urandom_range(0, 9) == 0) tv.sam_pm = ~tv.sam_pm;
            tv.button1   = 1'($urandom_range(0, 1));
            tv.button2   = 1'($urandom_range(0, 1));
            tv.set_alarm = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                tv.set_alarm = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    tv.stime_alarm = 20'($urandom);
                end else begin
                    t = (m_t + int'($urandom_range(1, 30))) % 86400;
                    tv.stime_alarm = enc_alarm(t, tv.mode12h);
                    if (tv.mode12h) tv.sam_pm = (t / 3600 >= 12);
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/time_view.md
Name: time_view

Overview:
- Real-time clock core that keeps hours, minutes and seconds in a 24-hour internal format.
- Supports manual time setting via two buttons plus an AM/PM select, and latches one alarm time.
- Presents the current time as a packed BCD display word in 12-hour or 24-hour form.
- Sits between the button/switch input layer and the 7-segment display driver.

Parameters:
- CLK_PER_SEC, default 1: clk cycles per one-second tick. Must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- mode12h  input  1  display format: 1 = 12-hour, 0 = 24-hour.
- set_time  input  1  level signal; 1 = time-set mode, during which counting is paused.
- set_alarm  input  1  a rising edge latches stime_alarm as the alarm time.
- button1  input  1  a rising edge in set mode increments the hour.
- button2  input  1  a rising edge in set mode increments the minute.
- stime_alarm  input  20  alarm time in packed BCD, same layout as hh_mm_ss.
- sam_pm  input  1  AM/PM select (1 = PM), used in set mode and in 12-hour alarm entry.
- hh_mm_ss  output  20  current time in BCD, MSB to LSB: hour tens [19:18], hour units [17:14], minute tens [13:11], minute units [10:7], second tens [6:4], second units [3:0].
- am_pm  output  1  1 when the internal hour is 12..23.
- alarm_hit  output  1  1 while an armed alarm equals the current time.

Behaviour:
- Reset (rst=0, asynchronous):
  - time is 00:00:00, tick counter 0, alarm disarmed;
  - hh_mm_ss=0, am_pm=0, alarm_hit=0;
  - button and set_alarm edge-detect registers cleared.
- Internal state: hour 0..23, min 0..59, sec 0..59 (binary), prescaler 0..CLK_PER_SEC-1.
- Run mode (set_time=0):
  - The prescaler counts every cycle.
  - On wrap of the prescaler, sec increments.
  - 59->0 carries into min, min 59->0 carries into hour, hour 23->0.
  - 23:59:59 -> 00:00:00.
- Set mode (set_time=1):
  - Prescaler and sec are held at 0.
  - Each cycle, hour is forced into the half selected by sam_pm: hour = (hour mod 12) + 12*sam_pm.
  - button1 rising edge: hour = ((hour mod 12)+1) mod 12 + 12*sam_pm. Examples: 11->0 for AM, 23->12 for PM.
  - button2 rising edge: min = (min+1) mod 60, with no carry into hour.
  - Both edges in the same cycle: both updates apply.
  - Leaving set mode resumes counting from the set time with sec=00.
- Buttons are edge-detected against their previous-cycle value. Edges outside set mode are ignored.
- Display: outputs are registered, so there is 1-cycle latency from internal state.
  - mode12h=0: hour shown as 00..23.
  - mode12h=1: hour shown as 12 for internal 0 or 12, otherwise hour mod 12.
  - am_pm reflects the internal hour regardless of mode.
  - Changing mode12h changes only the display, never the stored time.
- Alarm:
  - A set_alarm rising edge decodes stime_alarm.
  - If mode12h=1: the hour field 1..12 plus sam_pm is mapped to 24h (12 AM -> 0, 12 PM -> 12).
  - If mode12h=0: the hour field is taken as 0..23.
  - If any field is invalid (BCD digit >9, min/sec >59, hour out of range for the mode), the previous alarm is kept unchanged. Otherwise the value is stored and the alarm is armed.
  - alarm_hit is registered and high while armed and the time equals the alarm, so it stays high for one second in run mode.
  - alarm_hit is forced low in set mode.

Decomposition:
- Package time_view_pkg:
  - BCD field widths and bit positions for the 20-bit word;
  - limits MAX_HOUR=23 and MAX_MIN_SEC=59;
  - a function converting 0..59 to two BCD digits.
- One sub-module, time_bcd_fmt: combinational conversion of (hour, min, sec, mode12h) to the 20-bit BCD word. It is used for the display path.

Test Plan:
- Reset: hold rst=0, then release -> hh_mm_ss=0x00000, am_pm=0, alarm_hit=0.
- Set AM: set_time=1, sam_pm=0, 12 button1 edges and 12 button2 edges, mode12h=0 -> display 00:12:00, am_pm=0.
- Set PM: continuing, sam_pm=1, 12 more edges of each button -> display 12:24:00, am_pm=1. With mode12h=1 -> display 12:24:00, am_pm=1.
- Simultaneous buttons: button1 and button2 rising in the same cycle, starting from 12:24 PM -> 13:25:00.
- Run and wrap: CLK_PER_SEC=1, set 23:59 PM, drop set_time.
  - After 59 cycles -> 23:59:59.
  - On the next tick -> 00:00:00 with am_pm=0.
  - mode12h=1 shows hour 12.
- Alarm: mode12h=0, stime_alarm 01:32:46 (hour tens 0, hour units 1, minute tens 3, minute units 2, second tens 4, second units 6), pulse set_alarm, set time 01:32 then run -> alarm_hit rises when the display shows 01:32:46 and falls at 01:32:47. An invalid alarm with minute tens 7 leaves the previous alarm unchanged.
